// File: rtl/dmem_lsu_pkg.sv
// Shared definitions for the data-memory load/store unit.
//   - access size encodings (byte / half / word; the fourth code is illegal)
//   - FSM state enum for the LSU sequencer
//   - request legality check shared by the top level
package dmem_lsu_pkg;

  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;

  typedef enum logic [1:0] {
    IDLE,
    LD_WAIT,
    RMW_MERGE,
    RESP
  } state_t;

  // True when a request must be rejected: illegal size code, or a half/word
  // access that is not naturally aligned.
  function automatic logic req_is_err(input logic [1:0] size, input logic [1:0] off);
    logic err;
    case (size)
      SZ_B:    err = 1'b0;
      SZ_H:    err = off[0];
      SZ_W:    err = (off != 2'b00);
      default: err = 1'b1;
    endcase
    return err;
  endfunction

endpackage

// File: rtl/dmem_lane.sv
// Byte-lane steering for the load/store unit (purely combinational).
//   word        : 32-bit word as read from the RAM
//   offset      : byte offset of the access inside the word
//   size        : SZ_B / SZ_H / SZ_W
//   uns         : 1 = zero-extend loads, 0 = sign-extend
//   wdata       : right-justified store data (only the low half is ever merged)
//   load_data   : addressed lane, extended to 32 bits
//   merge_data  : word with the addressed byte/half replaced by wdata
module dmem_lane
  import dmem_lsu_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  offset,
  input  logic [1:0]  size,
  input  logic        uns,
  input  logic [15:0] wdata,
  output logic [31:0] load_data,
  output logic [31:0] merge_data
);

  logic [7:0]  lane_b;
  logic [15:0] lane_h;

  assign lane_b = word[{offset, 3'b000} +: 8];
  assign lane_h = offset[1] ? word[31:16] : word[15:0];

  always_comb begin
    // NOTE: every output gets a default before the case, so no path leaves
    // one unassigned and no latch is inferred.
    load_data  = '0;
    merge_data = word;
    case (size)
      SZ_B: begin
        load_data = {{24{lane_b[7] & ~uns}}, lane_b};
        merge_data[{offset, 3'b000} +: 8] = wdata[7:0];
      end
      SZ_H: begin
        load_data = {{16{lane_h[15] & ~uns}}, lane_h};
        merge_data[{offset[1], 4'b0000} +: 16] = wdata;
      end
      SZ_W:    load_data = word;
      default: ;
    endcase
  end

endmodule

// File: rtl/dmem_lsu.sv
// Load/store unit between the RV32 memory stage and a 32-bit dual-port RAM
// without byte enables. One request in flight; sub-word stores are done as
// read-modify-write; loads are lane-selected and extended.
//   clk, rst           : clock, synchronous active-high reset
//   req_*              : request handshake (valid/ready), we, size, unsigned,
//                        byte address, right-justified store data
//   rsp_valid/err/rdata: one-cycle completion pulse, error flag, load data
//   ram_wr*/ram_rd*    : RAM write and read ports (read data one cycle later)
module dmem_lsu
  import dmem_lsu_pkg::*;
#(
  parameter int DEPTH = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             req_we,
  input  logic [1:0]       req_size,
  input  logic             req_unsigned,
  input  logic [31:0]      req_addr,
  input  logic [31:0]      req_wdata,
  output logic             rsp_valid,
  output logic             rsp_err,
  output logic [31:0]      rsp_rdata,
  output logic             ram_wren,
  output logic [DEPTH-1:0] ram_wraddr,
  output logic [31:0]      ram_wrdata,
  output logic             ram_rden,
  output logic [DEPTH-1:0] ram_rdaddr,
  input  logic [31:0]      ram_rddata
);

  state_t           state, state_next;
  logic [DEPTH-1:0] word_q;
  logic [1:0]       off_q;
  logic [1:0]       size_q;
  logic             uns_q;
  logic [15:0]      wdata_q;

  logic             accept;
  logic             req_err;
  logic             req_word_st;
  logic [DEPTH-1:0] req_word;
  logic [31:0]      load_data;
  logic [31:0]      merge_data;

  // Address bits above the RAM index are ignored: accesses wrap.
  logic unused_addr;
  assign unused_addr = ^req_addr[31:DEPTH+2];

  assign req_word    = req_addr[DEPTH+1:2];
  assign req_ready   = (state == IDLE);
  assign accept      = req_valid && req_ready && !rst;
  assign req_err     = req_is_err(req_size, req_addr[1:0]);
  assign req_word_st = req_we && (req_size == SZ_W);
  assign rsp_valid   = (state == RESP);

  // The accept cycle drives the RAM straight from the live request; later
  // cycles use the latched word index.
  assign ram_rdaddr = (state == IDLE) ? req_word : word_q;
  assign ram_wraddr = (state == IDLE) ? req_word : word_q;

  dmem_lane u_lane (
    .word       (ram_rddata),
    .offset     (off_q),
    .size       (size_q),
    .uns        (uns_q),
    .wdata      (wdata_q),
    .load_data  (load_data),
    .merge_data (merge_data)
  );

  always_comb begin
    state_next = state;
    ram_rden   = 1'b0;
    ram_wren   = 1'b0;
    ram_wrdata = merge_data;
    case (state)
      IDLE: begin
        if (accept) begin
          if (req_err) begin
            state_next = RESP;
          end else if (req_word_st) begin
            ram_wren   = 1'b1;
            ram_wrdata = req_wdata;
            state_next = RESP;
          end else begin
            ram_rden   = 1'b1;
            state_next = req_we ? RMW_MERGE : LD_WAIT;
          end
        end
      end
      LD_WAIT:   state_next = RESP;
      RMW_MERGE: begin
        // Reset during the merge cycle must not corrupt the RAM word.
        ram_wren   = !rst;
        state_next = RESP;
      end
      RESP:      state_next = IDLE;
      default:   state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all registers
    // update together from values sampled at the same edge.
    if (rst) begin
      state     <= IDLE;
      rsp_err   <= 1'b0;
      rsp_rdata <= '0;
    end else begin
      state <= state_next;
      // Response fields are written only on the transition into RESP and
      // hold until the next response.
      case (state)
        IDLE: begin
          if (accept && (req_err || req_word_st)) begin
            rsp_err   <= req_err;
            rsp_rdata <= '0;
          end
        end
        LD_WAIT: begin
          rsp_err   <= 1'b0;
          rsp_rdata <= load_data;
        end
        RMW_MERGE: begin
          rsp_err   <= 1'b0;
          rsp_rdata <= '0;
        end
        default: ;
      endcase
    end
  end

  // NOTE: the request latches carry no reset; they are only consumed in
  // states that can be reached solely through an accept, which loads them.
  always_ff @(posedge clk) begin
    if (accept) begin
      word_q  <= req_word;
      off_q   <= req_addr[1:0];
      size_q  <= req_size;
      uns_q   <= req_unsigned;
      wdata_q <= req_wdata[15:0];
    end
  end

endmodule

// File: doc/dmem_lsu.md
Name: dmem_lsu

Overview:
Load/store unit between the RV32 core's memory stage and the 32-bit-wide dual-port block RAM.
- Accepts one byte, halfword or word request at a time.
- Performs read-modify-write for sub-word stores, because the RAM has no byte enables.
- Aligns and sign/zero-extends load data.
- Flags misaligned or illegal-size requests without touching memory.

Parameters:
DEPTH, 10, RAM word-address width; the RAM holds 2**DEPTH 32-bit words.

Ports:
clk  input  1  clock
rst  input  1  synchronous active-high reset
req_valid  input  1  request present
req_ready  output  1  LSU can accept a request
req_we  input  1  1 = store, 0 = load
req_size  input  2  0 = byte, 1 = half, 2 = word, 3 = illegal
req_unsigned  input  1  load zero-extends when 1, sign-extends when 0
req_addr  input  32  byte address
req_wdata  input  32  store data, right-justified
rsp_valid  output  1  one-cycle pulse when the request completes
rsp_err  output  1  misaligned or illegal request; qualified by rsp_valid
rsp_rdata  output  32  extended load data (0 for stores and errors)
ram_wren  output  1  RAM write enable
ram_wraddr  output  DEPTH  RAM write word address
ram_wrdata  output  32  RAM write data
ram_rden  output  1  RAM read enable
ram_rdaddr  output  DEPTH  RAM read word address
ram_rddata  input  32  RAM read data, valid one cycle after ram_rden

Behaviour:
- Clock and reset: single clock clk. rst is synchronous, active-high.
- Word index = req_addr[DEPTH+1:2]. Higher address bits are ignored, so addresses wrap modulo 4*2**DEPTH bytes.
- FSM states: IDLE, LD_WAIT, RMW_MERGE, RESP.
- req_ready = (state == IDLE). A request is accepted when req_valid && req_ready; address, size, lane and data are latched at acceptance.
- Error check on accept:
  - size 3 is illegal;
  - half with addr[0] = 1 is misaligned;
  - word with addr[1:0] != 0 is misaligned.
  - An error issues no RAM access and goes to RESP with rsp_err = 1.
- Load: ram_rden = 1 combinationally in the accept cycle, ram_rdaddr = word index, then go to LD_WAIT.
  - In LD_WAIT, select the lane from ram_rddata using addr[1:0] (byte) or addr[1] (half), extend it, register it into rsp_rdata, and go to RESP.
- Word store: ram_wren = 1 combinationally in the accept cycle, with ram_wrdata = req_wdata, then go to RESP.
- Sub-word store:
  - Accept cycle: ram_rden = 1, then go to RMW_MERGE.
  - In RMW_MERGE: ram_wren = 1, ram_wrdata = ram_rddata with only the addressed byte/half replaced by the latched wdata[7:0] or wdata[15:0]; then go to RESP.
- RESP: rsp_valid = 1 for exactly one cycle, then return to IDLE.
- Latency from accept to rsp_valid, with accept in cycle N:
  - load: 2 cycles (rsp_valid in cycle N+2);
  - sub-word store: 2 cycles;
  - word store: 1 cycle;
  - error: 1 cycle.
- ram_wraddr and ram_rdaddr always carry the active word index; they are don't-care when their enable is low.
- Only one operation is in flight at a time, so there is no read-during-write hazard.
- rsp_rdata and rsp_err hold their value until the next response is registered.
- Reset:
  - reset values: state = IDLE, rsp_valid = 0, rsp_err = 0, rsp_rdata = 0;
  - ram_wren and ram_rden are forced to 0 while rst = 1;
  - reset mid-operation aborts it: no write is issued and no response is produced, including during an RMW merge.
- rst = 1 together with req_valid = 1: the request is not accepted.

Decomposition:
- Shared core package holds:
  - size encodings SZ_B = 0, SZ_H = 1, SZ_W = 2;
  - FSM state enum.
- One natural sub-module, dmem_lane: combinational load extract/extend plus store merge, taking (word, offset, size, unsigned, wdata).

Test Plan:
- Word store of 0xDEADBEEF to 0x10, then word load from 0x10: the store gives ram_wren in the accept cycle and rsp_valid 1 cycle later; the load gives rsp_rdata = 0xDEADBEEF with rsp_valid 2 cycles after accept.
- Byte store of 0xA5 to 0x13 over a word holding 0x11223344: the RAM word becomes 0xA5223344. A signed byte load from 0x13 returns 0xFFFFFFA5; an unsigned load returns 0x000000A5.
- Half store of 0x8001 to 0x12, then half loads from 0x12: the word becomes 0x80013344; signed load returns 0xFFFF8001, unsigned returns 0x00008001.
- Misaligned word load at 0x02, half store at 0x05, and size 3: each gives rsp_valid with rsp_err = 1, rsp_rdata = 0, and no ram_wren/ram_rden pulse.
- rst asserted in the RMW_MERGE cycle of a byte store: ram_wren stays 0, the memory word is unchanged, there is no rsp_valid, and req_ready = 1 on the cycle after reset deasserts.
- Back-to-back requests with req_valid held high: req_ready drops during LD_WAIT/RMW_MERGE/RESP, requests are accepted only in IDLE, and none are dropped or duplicated.
